// File: rtl/row_pair_buffer.sv
// Row-indexed pairing buffer: parks the first partial sum per row and releases it with the second
// as an adder pair; an end-of-frame flush streams all parked rows to y in ascending order.
module row_pair_buffer #(
    parameter int WIDTH      = 66,
    parameter int DEPTH      = 1024,
    parameter int LOG2_DEPTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr0,
    input  logic [LOG2_DEPTH-1:0] row0,
    input  logic [WIDTH-1:0]      v0,
    input  logic                  wr1,
    input  logic [LOG2_DEPTH-1:0] row1,
    input  logic [WIDTH-1:0]      v1,
    output logic                  in_ready,
    input  logic                  eof,
    output logic                  push_to_adder,
    output logic [LOG2_DEPTH-1:0] row_to_adder,
    output logic [WIDTH-1:0]      v0_to_adder,
    output logic [WIDTH-1:0]      v1_to_adder,
    output logic                  push_to_y,
    output logic [LOG2_DEPTH-1:0] row_to_y,
    output logic [WIDTH-1:0]      v_to_y,
    output logic                  done,
    output logic                  proto_err
);

    localparam int FPW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int EW  = LOG2_DEPTH + 2 * WIDTH;
    localparam logic [LOG2_DEPTH-1:0] LAST_ROW = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [FPW-1:0]        LAST_PTR = FPW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_SCAN, S_TAIL, S_FIN} state_t;

    state_t state, state_nx;

    logic [DEPTH-1:0] occ;
    logic [WIDTH-1:0] mem [DEPTH];

    logic acc0, acc1, same_row, hit0, hit1, st0, st1, scan_rd;
    logic [2:0] inflight;

    // Stage 1: RAM read data plus the newly arrived operands.
    logic                  s1_p0, s1_p1, s1_dir;
    logic [LOG2_DEPTH-1:0] s1_row0, s1_row1;
    logic [WIDTH-1:0]      s1_v0, s1_v1, s1_rd0, s1_rd1;

    // Stage 2: assembled pair entries awaiting the FIFO write.
    logic          s2_p0, s2_p1;
    logic [EW-1:0] s2_e0, s2_e1;

    logic [EW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [FPW-1:0] wr_ptr, rd_ptr;
    logic [FCW-1:0] fifo_count;
    logic           pop;
    logic [1:0]     n_wr;

    logic [LOG2_DEPTH-1:0] scan_idx;
    logic                  sc1_valid;
    logic [LOG2_DEPTH-1:0] sc1_row;
    logic [WIDTH-1:0]      sc1_val;

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = {2'b00, s1_p0} + {2'b00, s1_p1} + {2'b00, s2_p0} + {2'b00, s2_p1};
        in_ready = !rst && (state == S_RUN) &&
                   (32'(fifo_count) + 32'(inflight) + 32'd2 <= 32'(FIFO_DEPTH));
        acc0     = wr0 && in_ready;
        acc1     = wr1 && in_ready;
        same_row = acc0 && acc1 && (row0 == row1);
        hit0     = acc0 && !same_row && occ[row0];
        st0      = acc0 && !same_row && !occ[row0];
        hit1     = acc1 && !same_row && occ[row1];
        st1      = acc1 && !same_row && !occ[row1];
        scan_rd  = (state == S_SCAN) && occ[scan_idx];
        pop      = (fifo_count != '0);
        n_wr     = {1'b0, s2_p0} + {1'b0, s2_p1};
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RUN:   if (eof) state_nx = S_DRAIN;
            S_DRAIN: if (inflight == '0 && fifo_count == '0) state_nx = S_SCAN;
            S_SCAN:  if (scan_idx == LAST_ROW) state_nx = S_TAIL;
            S_TAIL:  state_nx = S_FIN;
            S_FIN:   state_nx = S_RUN;
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else begin
            if (hit0) occ[row0] <= 1'b0;
            if (st0)  occ[row0] <= 1'b1;
            if (hit1) occ[row1] <= 1'b0;
            if (st1)  occ[row1] <= 1'b1;
            if (scan_rd) occ[scan_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (st0) mem[row0] <= v0;
        if (st1) mem[row1] <= v1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p0  <= 1'b0;
            s1_p1  <= 1'b0;
            s1_dir <= 1'b0;
            s2_p0  <= 1'b0;
            s2_p1  <= 1'b0;
        end else begin
            s1_p0  <= hit0 || same_row;
            s1_p1  <= hit1;
            s1_dir <= same_row;
            s2_p0  <= s1_p0;
            s2_p1  <= s1_p1;
        end
    end

    // A same-row dual write rides the lane-0 slot with (v0, v1) so it keeps the common latency.
    always_ff @(posedge clk) begin
        s1_row0 <= row0;
        s1_row1 <= row1;
        s1_v0   <= v0;
        s1_v1   <= v1;
        if (hit0) s1_rd0 <= mem[row0];
        if (hit1) s1_rd1 <= mem[row1];
        s2_e0 <= {s1_row0, (s1_dir ? s1_v0 : s1_rd0), (s1_dir ? s1_v1 : s1_v0)};
        s2_e1 <= {s1_row1, s1_rd1, s1_v1};
    end

    always_ff @(posedge clk) begin
        if (s2_p0) fifo_mem[wr_ptr] <= s2_e0;
        if (s2_p1) fifo_mem[s2_p0 ? ptr_inc(wr_ptr) : wr_ptr] <= s2_e1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            push_to_adder <= 1'b0;
            row_to_adder  <= '0;
            v0_to_adder   <= '0;
            v1_to_adder   <= '0;
        end else begin
            if (s2_p0 && s2_p1)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            else if (s2_p0 || s2_p1) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                {row_to_adder, v0_to_adder, v1_to_adder} <= fifo_mem[rd_ptr];
            end
            push_to_adder <= pop;
            fifo_count    <= fifo_count + FCW'(n_wr) - FCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        sc1_row <= scan_idx;
        if (scan_rd) sc1_val <= mem[scan_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx  <= '0;
            sc1_valid <= 1'b0;
            push_to_y <= 1'b0;
            row_to_y  <= '0;
            v_to_y    <= '0;
            done      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (state == S_SCAN) scan_idx <= scan_idx + 1'b1;
            else                 scan_idx <= '0;
            sc1_valid <= scan_rd;
            push_to_y <= sc1_valid;
            if (sc1_valid) begin
                row_to_y <= sc1_row;
                v_to_y   <= sc1_val;
            end
            done <= (state == S_FIN);
            if (((wr0 || wr1) && !in_ready) || (eof && state != S_RUN))
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_row_pair_buffer.sv
// Directed bench for row_pair_buffer: per-cycle vector table for pairing latency and order,
// plus hand-written sequences for flush, backpressure, protocol errors and mid-flush reset.
module tb_row_pair_buffer;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int LD = 4;
    localparam int FD = 8;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr0 = 1'b0, wr1 = 1'b0, eof = 1'b0;
    logic [LD-1:0] row0 = '0, row1 = '0;
    logic [W-1:0]  v0 = '0, v1 = '0;
    logic          in_ready, push_to_adder, push_to_y, done, proto_err;
    logic [LD-1:0] row_to_adder, row_to_y;
    logic [W-1:0]  v0_to_adder, v1_to_adder, v_to_y;

    row_pair_buffer #(.WIDTH(W), .DEPTH(D), .LOG2_DEPTH(LD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .wr0(wr0), .row0(row0), .v0(v0),
        .wr1(wr1), .row1(row1), .v1(v1),
        .in_ready(in_ready), .eof(eof),
        .push_to_adder(push_to_adder), .row_to_adder(row_to_adder),
        .v0_to_adder(v0_to_adder), .v1_to_adder(v1_to_adder),
        .push_to_y(push_to_y), .row_to_y(row_to_y), .v_to_y(v_to_y),
        .done(done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr0;
        logic [LD-1:0] row0;
        logic [W-1:0]  v0;
        logic          wr1;
        logic [LD-1:0] row1;
        logic [W-1:0]  v1;
        logic          e_push;
        logic [LD-1:0] e_row;
        logic [W-1:0]  e_a;
        logic [W-1:0]  e_b;
    } vec_t;

    typedef struct { logic [LD-1:0] row; logic [W-1:0] a; logic [W-1:0] b; } pair_t;
    typedef struct { logic [LD-1:0] row; logic [W-1:0] v; int c; } ypush_t;

    vec_t   tbl [NV];
    pair_t  pair_q [$];
    ypush_t y_q [$];
    int     n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pair_t  p;
        ypush_t y;
        if (!rst) begin
            if (push_to_adder) begin
                p.row = row_to_adder; p.a = v0_to_adder; p.b = v1_to_adder;
                pair_q.push_back(p);
            end
            if (push_to_y) begin
                y.row = row_to_y; y.v = v_to_y; y.c = cyc;
                y_q.push_back(y);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w0, input logic [LD-1:0] r0, input logic [W-1:0] d0,
                                input logic w1, input logic [LD-1:0] r1, input logic [W-1:0] d1,
                                input logic ep, input logic [LD-1:0] er,
                                input logic [W-1:0] ea, input logic [W-1:0] eb);
        vec_t t;
        t.wr0 = w0; t.row0 = r0; t.v0 = d0; t.wr1 = w1; t.row1 = r1; t.v1 = d1;
        t.e_push = ep; t.e_row = er; t.e_a = ea; t.e_b = eb;
        return t;
    endfunction

    task automatic step(input logic w0, input logic [LD-1:0] r0, input logic [W-1:0] d0,
                        input logic w1, input logic [LD-1:0] r1, input logic [W-1:0] d1,
                        input logic e);
        @(negedge clk); #1;
        wr0 = w0; row0 = r0; v0 = d0; wr1 = w1; row1 = r1; v1 = d1; eof = e;
        @(posedge clk); #1;
        wr0 = 1'b0; wr1 = 1'b0; eof = 1'b0;
    endtask

    // kind 0: pairs seen, 1: y pushes seen, 2: done pulses seen
    task automatic wait_cnt(input int kind, input int n, input string nm);
        int t = 0;
        int got;
        got = (kind == 0) ? pair_q.size() : (kind == 1) ? y_q.size() : done_cnt;
        while (got < n && t < 300) begin
            @(negedge clk); #1;
            t++;
            got = (kind == 0) ? pair_q.size() : (kind == 1) ? y_q.size() : done_cnt;
        end
        check({nm, " timeout"}, 64'(got >= n), 64'(1));
    endtask

    task automatic check_pair(input string nm, input int idx, input logic [LD-1:0] r,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        pair_t p;
        if (idx < pair_q.size()) begin
            p = pair_q[idx];
            check({nm, " row"}, 64'(p.row), 64'(r));
            check({nm, " a"},   64'(p.a),   64'(a));
            check({nm, " b"},   64'(p.b),   64'(b));
        end else begin
            check({nm, " present"}, 64'(pair_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_y(input string nm, input int idx, input logic [LD-1:0] r,
                           input logic [W-1:0] v);
        if (idx < y_q.size()) begin
            check({nm, " row"}, 64'(y_q[idx].row), 64'(r));
            check({nm, " v"},   64'(y_q[idx].v),   64'(v));
        end else begin
            check({nm, " present"}, 64'(y_q.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " push_to_adder"}, 64'(push_to_adder), 64'(0));
        check({nm, " row_to_adder"},  64'(row_to_adder),  64'(0));
        check({nm, " v0_to_adder"},   64'(v0_to_adder),   64'(0));
        check({nm, " v1_to_adder"},   64'(v1_to_adder),   64'(0));
        check({nm, " push_to_y"},     64'(push_to_y),     64'(0));
        check({nm, " row_to_y"},      64'(row_to_y),      64'(0));
        check({nm, " v_to_y"},        64'(v_to_y),        64'(0));
        check({nm, " done"},          64'(done),          64'(0));
        check({nm, " proto_err"},     64'(proto_err),     64'(0));
        check({nm, " in_ready"},      64'(in_ready),      64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int saw_nr;
        int base;

        for (int i = 0; i < NV; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = mk(1, 5, 16'h0A0A, 0, 0, 0,        0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 16'h0B0B, 0, 0, 0,        0, 0, 0, 0);
        tbl[3]  = mk(1, 3, 16'h0C0C, 1, 3, 16'h0D0D, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,        0, 0, 0,        1, 5, 16'h0A0A, 16'h0B0B);
        tbl[6]  = mk(0, 0, 0,        0, 0, 0,        1, 3, 16'h0C0C, 16'h0D0D);
        tbl[7]  = mk(1, 7, 16'h0E0E, 1, 8, 16'h0F0F, 0, 0, 0, 0);
        tbl[8]  = mk(1, 8, 16'h1010, 1, 7, 16'h1111, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0,        0, 0, 0,        1, 8, 16'h0F0F, 16'h1010);
        tbl[12] = mk(0, 0, 0,        0, 0, 0,        1, 7, 16'h0E0E, 16'h1111);
        tbl[13] = mk(1, 1, 16'h1212, 1, 4, 16'h1313, 0, 0, 0, 0);
        tbl[14] = mk(1, 4, 16'h1414, 1, 1, 16'h1515, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0,        0, 0, 0,        1, 4, 16'h1313, 16'h1414);
        tbl[18] = mk(0, 0, 0,        0, 0, 0,        1, 1, 16'h1212, 16'h1515);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); #1;
        rst = 1'b0;

        // Pairing latency, direct same-row pairs, dual-lane ordering
        for (int i = 0; i < NV; i++) begin
            @(negedge clk); #1;
            wr0 = tbl[i].wr0; row0 = tbl[i].row0; v0 = tbl[i].v0;
            wr1 = tbl[i].wr1; row1 = tbl[i].row1; v1 = tbl[i].v1;
            @(posedge clk); #1;
            wr0 = 1'b0; wr1 = 1'b0;
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(1));
            check($sformatf("vec%0d push_to_adder", i), 64'(push_to_adder), 64'(tbl[i].e_push));
            check($sformatf("vec%0d push_to_y", i), 64'(push_to_y), 64'(0));
            if (tbl[i].e_push) begin
                check($sformatf("vec%0d row", i), 64'(row_to_adder), 64'(tbl[i].e_row));
                check($sformatf("vec%0d v0", i),  64'(v0_to_adder),  64'(tbl[i].e_a));
                check($sformatf("vec%0d v1", i),  64'(v1_to_adder),  64'(tbl[i].e_b));
            end
        end

        // Ordered flush of rows 9, 2, 14; then an empty flush
        pair_q.delete(); y_q.delete(); done_cnt = 0;
        step(1, 9,  16'h0909, 0, 0, 0, 0);
        step(1, 2,  16'h0202, 0, 0, 0, 0);
        step(1, 14, 16'h0E14, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 1);
        base = cyc;
        check("flush in_ready low", 64'(in_ready), 64'(0));
        wait_cnt(2, 1, "flush1 done");
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("flush1 y count", 64'(y_q.size()), 64'(3));
        check_y("flush1 y0", 0, 2,  16'h0202);
        check_y("flush1 y1", 1, 9,  16'h0909);
        check_y("flush1 y2", 2, 14, 16'h0E14);
        check("flush1 done count", 64'(done_cnt), 64'(1));
        check("flush1 done after last y", 64'(y_q.size() == 3 && done_cyc > y_q[2].c), 64'(1));
        check("flush1 length", 64'(done_cyc - base >= D), 64'(1));
        check("flush1 no pairs", 64'(pair_q.size()), 64'(0));
        y_q.delete(); done_cnt = 0;
        step(0, 0, 0, 0, 0, 0, 1);
        wait_cnt(2, 1, "flush2 done");
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("flush2 y count", 64'(y_q.size()), 64'(0));
        check("flush2 done count", 64'(done_cnt), 64'(1));

        // Backpressure: pre-store rows 0..15, then dual retrieves
        pair_q.delete();
        for (int i = 0; i < 8; i++)
            step(1, LD'(2 * i), W'(32'h1000 + 2 * i), 1, LD'(2 * i + 1), W'(32'h1001 + 2 * i), 0);
        acc = 0; saw_nr = 0;
        for (int t = 0; t < 200 && acc < 8; t++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                wr0 = 1'b1; row0 = LD'(2 * acc);     v0 = W'(32'h2000 + 2 * acc);
                wr1 = 1'b1; row1 = LD'(2 * acc + 1); v1 = W'(32'h2001 + 2 * acc);
                @(posedge clk); #1;
                acc++;
            end else begin
                saw_nr = 1;
                @(posedge clk); #1;
            end
            wr0 = 1'b0; wr1 = 1'b0;
        end
        check("bp accepted", 64'(acc), 64'(8));
        check("bp in_ready dropped", 64'(saw_nr), 64'(1));
        wait_cnt(0, 16, "bp pairs");
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("bp pair count", 64'(pair_q.size()), 64'(16));
        for (int k = 0; k < 16; k++)
            check_pair($sformatf("bp pair%0d", k), k, LD'(k), W'(32'h1000 + k), W'(32'h2000 + k));
        check("bp proto_err", 64'(proto_err), 64'(0));

        // Protocol errors: wr during DRAIN, eof during SCAN
        pair_q.delete(); y_q.delete(); done_cnt = 0;
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 6, 16'hDEAD, 0, 0, 0, 0);
        check("perr after dropped wr", 64'(proto_err), 64'(1));
        repeat (3) @(posedge clk);
        step(0, 0, 0, 0, 0, 0, 1);
        wait_cnt(2, 1, "perr done");
        repeat (25) @(posedge clk);
        @(negedge clk); #1;
        check("perr done count", 64'(done_cnt), 64'(1));
        check("perr y count", 64'(y_q.size()), 64'(0));
        check("perr sticky", 64'(proto_err), 64'(1));
        step(1, 6, 16'h6161, 0, 0, 0, 0);
        step(1, 6, 16'h6262, 0, 0, 0, 0);
        wait_cnt(0, 1, "perr row6 pair");
        check_pair("perr row6", 0, 6, 16'h6161, 16'h6262);
        check("perr still set", 64'(proto_err), 64'(1));

        // Reset mid-SCAN after two y pushes
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        pair_q.delete(); y_q.delete(); done_cnt = 0;
        step(1, 1, 16'h7101, 0, 0, 0, 0);
        step(1, 2, 16'h7202, 0, 0, 0, 0);
        step(1, 5, 16'h7505, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        wait_cnt(1, 2, "rst y pushes");
        check_y("rst y0", 0, 1, 16'h7101);
        check_y("rst y1", 1, 2, 16'h7202);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midscan reset");
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        check("rst no done", 64'(done_cnt), 64'(0));
        check("rst no more y", 64'(y_q.size()), 64'(2));
        step(1, 2, 16'h8202, 0, 0, 0, 0);
        step(1, 2, 16'h8303, 0, 0, 0, 0);
        step(1, 5, 16'h8505, 0, 0, 0, 0);
        step(1, 5, 16'h8606, 0, 0, 0, 0);
        wait_cnt(0, 2, "rst pairs");
        check_pair("rst row2", 0, 2, 16'h8202, 16'h8303);
        check_pair("rst row5", 1, 5, 16'h8505, 16'h8606);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
